// File: rtl/adc_pair_sequencer_if.sv
// ADC-side handshake bundle for the two-channel sampling sequencer.
// master = sequencer side (drives enables), slave = ADC engine side.
interface adc_pair_sequencer_if;
    localparam int unsigned DATA_W = 16;

    logic              adc1_ready_i;
    logic [DATA_W-1:0] adc1_data_i;
    logic              adc1_enable_o;
    logic              adc2_ready_i;
    logic [DATA_W-1:0] adc2_data_i;
    logic              adc2_enable_o;

    modport master (
        input  adc1_ready_i, adc1_data_i, adc2_ready_i, adc2_data_i,
        output adc1_enable_o, adc2_enable_o
    );

    modport slave (
        output adc1_ready_i, adc1_data_i, adc2_ready_i, adc2_data_i,
        input  adc1_enable_o, adc2_enable_o
    );
endinterface

// File: rtl/adc_pair_sequencer.sv
// PWM-triggered sampler for the flying-cap / output ADC pair: arms both engines,
// captures and scales each result, pulses eoc per complete pair, with timeouts.
module adc_pair_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 54000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        trigger_i,
    input  logic                        fault_clr_i,
    adc_pair_sequencer_if.master        adc,
    output logic [15:0]                 vfc_o,
    output logic [15:0]                 vout_o,
    output logic                        eoc_o,
    output logic                        busy_o,
    output logic [1:0]                  fault_o,
    output logic [7:0]                  overrun_cnt_o
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned OVR_W  = 8;
    localparam logic [CNT_W-1:0] TIMER_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [OVR_W-1:0] OVR_MAX    = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_CONV  = 2'd2,
        S_ABORT = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic               done1_q, done1_d;
    logic               done2_q, done2_d;
    logic               en1_q, en1_d;
    logic               en2_q, en2_d;
    logic [DATA_W-1:0]  vfc_q, vfc_d;
    logic [DATA_W-1:0]  vout_q, vout_d;
    logic               eoc_q, eoc_d;
    logic               busy_q, busy_d;
    logic [1:0]         fault_q, fault_d;
    logic [OVR_W-1:0]   ovr_q, ovr_d;
    logic [1:0]         fault_set;

    // Negative readings clamp to zero; positive ones scale by two.
    function automatic logic [DATA_W-1:0] to_volts(input logic [DATA_W-1:0] raw);
        return raw[DATA_W-1] ? '0 : {raw[DATA_W-2:0], 1'b0};
    endfunction

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        done1_d   = done1_q;
        done2_d   = done2_q;
        en1_d     = en1_q;
        en2_d     = en2_q;
        vfc_d     = vfc_q;
        vout_d    = vout_q;
        eoc_d     = 1'b0;
        fault_set = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (trigger_i) begin
                    en1_d   = 1'b1;
                    en2_d   = 1'b1;
                    done1_d = 1'b0;
                    done2_d = 1'b0;
                    timer_d = TIMER_LOAD;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (!adc.adc1_ready_i && !adc.adc2_ready_i) begin
                    timer_d = TIMER_LOAD;
                    state_d = S_CONV;
                end else if (timer_q == '0) begin
                    state_d = S_ABORT;
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            S_CONV: begin
                if (adc.adc1_ready_i && !done1_q) begin
                    vfc_d   = to_volts(adc.adc1_data_i);
                    en1_d   = 1'b0;
                    done1_d = 1'b1;
                end
                if (adc.adc2_ready_i && !done2_q) begin
                    vout_d  = to_volts(adc.adc2_data_i);
                    en2_d   = 1'b0;
                    done2_d = 1'b1;
                end
                // Completion is judged on the registered flags, so eoc trails the last capture by one cycle.
                if (done1_q && done2_q) begin
                    eoc_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (timer_q == '0) begin
                    state_d = S_ABORT;
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            S_ABORT: begin
                en1_d     = 1'b0;
                en2_d     = 1'b0;
                fault_set = {~done2_q, ~done1_q};
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Clear applies first so a coincident set or increment survives.
        fault_d = (fault_clr_i ? 2'b00 : fault_q) | fault_set;
        ovr_d   = fault_clr_i ? '0 : ovr_q;
        if (trigger_i && (state_q != S_IDLE)) begin
            ovr_d = (ovr_q == OVR_MAX) ? OVR_MAX : ovr_q + OVR_W'(1);
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            done1_q <= 1'b0;
            done2_q <= 1'b0;
            en1_q   <= 1'b0;
            en2_q   <= 1'b0;
            vfc_q   <= '0;
            vout_q  <= '0;
            eoc_q   <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= '0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            done1_q <= done1_d;
            done2_q <= done2_d;
            en1_q   <= en1_d;
            en2_q   <= en2_d;
            vfc_q   <= vfc_d;
            vout_q  <= vout_d;
            eoc_q   <= eoc_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
            ovr_q   <= ovr_d;
        end
    end

    assign adc.adc1_enable_o = en1_q;
    assign adc.adc2_enable_o = en2_q;
    assign vfc_o             = vfc_q;
    assign vout_o            = vout_q;
    assign eoc_o             = eoc_q;
    assign busy_o            = busy_q;
    assign fault_o           = fault_q;
    assign overrun_cnt_o     = ovr_q;

endmodule

// File: tb/tb_adc_pair_sequencer.sv
// Bench for adc_pair_sequencer: directed vector table, multi-cycle corner sequences,
// then randomized transactions against a transaction-level outcome model.
module tb_adc_pair_sequencer;

    localparam int unsigned TO = 120;

    typedef struct {
        int          w1;    // last edge at which ready1 is still high during ARM
        int          w2;
        int          c1;    // edges after CONV entry until ready1 is sampled high
        int          c2;
        logic [15:0] d1;
        logic [15:0] d2;
    } stim_t;

    typedef struct {
        logic [15:0] vfc;
        logic [15:0] vout;
        logic [1:0]  fault;
        int          eoc_at;   // edge index after which eoc is seen, -1 for none
        int          en1f;
        int          en2f;
        int          idle;     // edge index after which busy is low
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trigger;
    logic        fault_clr;
    logic [15:0] vfc;
    logic [15:0] vout;
    logic        eoc;
    logic        busy;
    logic [1:0]  fault;
    logic [7:0]  ovr;

    int tests = 0;
    int fails = 0;

    logic [15:0] m_vfc;
    logic [15:0] m_vout;
    logic [1:0]  m_fault;
    int          m_ovr;

    adc_pair_sequencer_if bus ();

    adc_pair_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .trigger_i    (trigger),
        .fault_clr_i  (fault_clr),
        .adc          (bus),
        .vfc_o        (vfc),
        .vout_o       (vout),
        .eoc_o        (eoc),
        .busy_o       (busy),
        .fault_o      (fault),
        .overrun_cnt_o(ovr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] volts(input logic [15:0] raw);
        int v;
        v = int'($signed(raw));
        return (v < 0) ? 16'd0 : 16'(v * 2);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_vfc"},  vfc,  0);
        check({tag, "_vout"}, vout, 0);
        check({tag, "_eoc"},  eoc,  0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fault"}, fault, 0);
        check({tag, "_ovr"},  ovr,  0);
        check({tag, "_en1"},  bus.adc1_enable_o, 0);
        check({tag, "_en2"},  bus.adc2_enable_o, 0);
    endtask

    task automatic wait_idle(input int limit, input string tag);
        int n = 0;
        while (busy && n < limit) begin
            step();
            n++;
        end
        check({tag, "_idle_reached"}, busy, 0);
    endtask

    // Outcome of one trigger worked out from the timing rules, not from any state machine.
    task automatic predict(input stim_t s, output exp_t e);
        int a;
        int m;
        a = ((s.w1 > s.w2) ? s.w1 : s.w2) + 1;
        e.eoc_at = -1;
        if (a > int'(TO)) begin
            e.idle  = TO + 1;
            e.en1f  = e.idle;
            e.en2f  = e.idle;
            m_fault = 2'b11;
        end else begin
            m = (s.c1 > s.c2) ? s.c1 : s.c2;
            if (m + 1 <= int'(TO)) begin
                e.eoc_at = a + m + 1;
                e.idle   = e.eoc_at;
                e.en1f   = a + s.c1;
                e.en2f   = a + s.c2;
                m_vfc    = volts(s.d1);
                m_vout   = volts(s.d2);
            end else begin
                e.idle = a + TO + 1;
                if (s.c1 <= int'(TO)) begin
                    e.en1f = a + s.c1;
                    m_vfc  = volts(s.d1);
                end else begin
                    e.en1f     = e.idle;
                    m_fault[0] = 1'b1;
                end
                if (s.c2 <= int'(TO)) begin
                    e.en2f = a + s.c2;
                    m_vout = volts(s.d2);
                end else begin
                    e.en2f     = e.idle;
                    m_fault[1] = 1'b1;
                end
            end
        end
        e.vfc   = m_vfc;
        e.vout  = m_vout;
        e.fault = m_fault;
    endtask

    // Drives one trigger transaction edge by edge; edge 0 samples the trigger.
    task automatic run_pair(input stim_t s, input exp_t e, input bit rnd_trig,
                            input bit chain, input string tag);
        int a;
        int eoc_n = 0;
        int eoc_at = -1;
        int en1f = -1;
        int en2f = -1;
        int bf = -1;
        int ntrig = 0;
        bit start_ok = 1'b0;
        a = ((s.w1 > s.w2) ? s.w1 : s.w2) + 1;
        fault_clr = 1'b0;
        bus.adc1_data_i = s.d1;
        bus.adc2_data_i = s.d2;
        for (int k = 0; k <= e.idle + 1; k++) begin
            trigger = (k == 0) || (chain && (k == e.idle + 1));
            if (rnd_trig && k >= 1 && k <= e.idle && $urandom_range(3) == 0) begin
                trigger = 1'b1;
                ntrig++;
            end
            bus.adc1_ready_i = !((k >= s.w1 + 1) && (k < a + s.c1));
            bus.adc2_ready_i = !((k >= s.w2 + 1) && (k < a + s.c2));
            step();
            if (k == 0) start_ok = bus.adc1_enable_o && bus.adc2_enable_o && busy;
            if (eoc) begin
                eoc_n++;
                if (eoc_at < 0) eoc_at = k;
            end
            if (k >= 1 && !bus.adc1_enable_o && en1f < 0) en1f = k;
            if (k >= 1 && !bus.adc2_enable_o && en2f < 0) en2f = k;
            if (!busy && bf < 0) bf = k;
        end
        trigger = 1'b0;
        m_ovr = (m_ovr + ntrig > 255) ? 255 : m_ovr + ntrig;
        check({tag, "_start"},    start_ok, 1);
        check({tag, "_eoc_count"}, eoc_n, (e.eoc_at >= 0) ? 1 : 0);
        check({tag, "_eoc_edge"}, eoc_at, e.eoc_at);
        check({tag, "_en1_fall"}, en1f, e.en1f);
        check({tag, "_en2_fall"}, en2f, e.en2f);
        check({tag, "_busy_fall"}, bf, e.idle);
        check({tag, "_vfc"},   vfc,   e.vfc);
        check({tag, "_vout"},  vout,  e.vout);
        check({tag, "_fault"}, fault, e.fault);
        check({tag, "_ovr"},   ovr,   m_ovr);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl [8];
        stim_t s;
        exp_t  e;

        tbl[0] = '{'{2, 2, 100, 100, 16'h1234, 16'h0800}, '{16'h2468, 16'h1000, 2'b00, 104, 103, 103, 104}};
        tbl[1] = '{'{2, 2, 50, 100, 16'h7FFF, 16'h8001}, '{16'hFFFE, 16'h0000, 2'b00, 104, 53, 103, 104}};
        tbl[2] = '{'{0, 0, 119, 5, 16'h0010, 16'hFFFF}, '{16'h0020, 16'h0000, 2'b00, 121, 120, 6, 121}};
        tbl[3] = '{'{0, 0, 120, 5, 16'h0102, 16'h0003}, '{16'h0204, 16'h0006, 2'b00, -1, 121, 6, 122}};
        tbl[4] = '{'{2, 2, 10, 200, 16'h0001, 16'h1111}, '{16'h0002, 16'h0006, 2'b10, -1, 13, 124, 124}};
        tbl[5] = '{'{0, 500, 1, 1, 16'h5555, 16'h5555}, '{16'h0002, 16'h0006, 2'b11, -1, 121, 121, 121}};
        tbl[6] = '{'{0, 0, 1, 1, 16'h4000, 16'h0001}, '{16'h8000, 16'h0002, 2'b11, 3, 2, 2, 3}};
        tbl[7] = '{'{119, 3, 2, 2, 16'h0ABC, 16'h0300}, '{16'h1578, 16'h0600, 2'b11, 123, 122, 122, 123}};

        rst_n = 1'b0;
        trigger = 1'b0;
        fault_clr = 1'b0;
        bus.adc1_ready_i = 1'b1;
        bus.adc2_ready_i = 1'b1;
        bus.adc1_data_i = '0;
        bus.adc2_data_i = '0;
        m_ovr = 0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run_pair(tbl[i].s, tbl[i].e, 1'b0, 1'b0, $sformatf("vec%0d", i));
        end

        // Trigger in the eoc cycle restarts and is not an overrun.
        s = '{0, 0, 3, 3, 16'h0100, 16'h0200};
        e = '{16'h0200, 16'h0400, 2'b11, 5, 4, 4, 5};
        run_pair(s, e, 1'b0, 1'b1, "chain");
        check("chain_busy", busy, 1);
        check("chain_en1", bus.adc1_enable_o, 1);
        check("chain_en2", bus.adc2_enable_o, 1);
        check("chain_ovr", ovr, 0);
        wait_idle(TO + 5, "chain");
        check("chain_fault", fault, 2'b11);

        // Hold trigger through several timed-out arms to drive the counter past 255.
        trigger = 1'b1;
        for (int i = 0; i < 400; i++) step();
        trigger = 1'b0;
        wait_idle(TO + 5, "ovr");
        check("ovr_saturated", ovr, 255);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check("clr_ovr", ovr, 0);
        check("clr_fault", fault, 0);
        check("clr_vfc_kept", vfc, 16'h0200);

        // Asynchronous reset while converting.
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        bus.adc1_ready_i = 1'b0;
        bus.adc2_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("midconv_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.adc1_ready_i = 1'b1;
        bus.adc2_ready_i = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 6; i++) begin
                step();
                if (eoc || busy) seen++;
            end
            check("post_reset_quiet", seen, 0);
        end

        m_vfc = '0;
        m_vout = '0;
        m_fault = '0;
        m_ovr = 0;
        for (int t = 0; t < 24; t++) begin
            s.w1 = $urandom_range(6);
            s.w2 = $urandom_range(6);
            if ($urandom_range(7) == 0) s.w2 = TO + 5;
            s.c1 = $urandom_range(40, 1);
            s.c2 = $urandom_range(40, 1);
            if ($urandom_range(7) == 0) s.c1 = TO + $urandom_range(3);
            if ($urandom_range(7) == 0) s.c2 = TO + $urandom_range(3);
            s.d1 = 16'($urandom);
            s.d2 = 16'($urandom);
            predict(s, e);
            run_pair(s, e, 1'b1, 1'b0, $sformatf("rnd%0d", t));
            if ($urandom_range(3) == 0) begin
                fault_clr = 1'b1;
                step();
                fault_clr = 1'b0;
                m_fault = '0;
                m_ovr = 0;
                check($sformatf("rnd%0d_clr_fault", t), fault, m_fault);
                check($sformatf("rnd%0d_clr_ovr", t), ovr, m_ovr);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
